// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver. The serial line is resynchronised with two flops and
//   then sampled at bit centres by a counter-timed FSM. A good frame updates
//   data_byte and pulses flag. A frame whose stop bit samples low pulses
//   frame_err and then waits for the line to return high.
//
// Parameters
//   CLKS_PER_BIT  system clocks per serial bit (>= 4)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   data_line  in   serial input, idles high, LSB first
//   flag       out  one-cycle pulse: new byte on data_byte
//   data_byte  out  last correctly framed byte
//   frame_err  out  one-cycle pulse: stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_line,
    output logic       flag,
    output logic [7:0] data_byte,
    output logic       frame_err
);

    localparam int H     = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       byte_q, byte_d;
    logic             flag_q, flag_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;

    // Synchronised view of the line; every FSM decision uses this bit only.
    assign rx_s   = sync_q[1];
    assign sync_d = {sync_q[0], data_line};

    // Next-state and datapath logic for the receive FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        byte_d  = byte_q;
        flag_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                // Re-check the start bit half a bit later to reject glitches.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    sh_d[idx_q] = rx_s;
                    cnt_d       = '0;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_d  = sh_q;
                        flag_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                // A line held low after a bad stop must not look like a new start.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State, counters, synchroniser and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            sh_q    <= 8'h00;
            byte_q  <= 8'h00;
            flag_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            byte_q  <= byte_d;
            flag_q  <= flag_d;
            ferr_q  <= ferr_d;
        end
    end

    assign flag      = flag_q;
    assign data_byte = byte_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx. dut_a runs at 8 clocks per bit, dut_b at 16.
//   Lines are driven on falling edges; outputs are observed on falling edges.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       line_a, line_b;
    logic       flag_a, flag_b;
    logic       ferr_a, ferr_b;
    logic [7:0] byte_a, byte_b;

    int cyc;
    int n_checks;
    int n_pass;

    // Observation counters for dut_a
    int fa_hi, fa_pulses, fa_last_cyc, fa_prev_cyc;
    int ea_hi, ea_pulses, both_a;
    logic [7:0] fa_last_byte, fa_prev_byte;
    logic flag_a_prev, ferr_a_prev;
    // Observation counters for dut_b
    int fb_pulses, fb_last_cyc, eb_pulses, both_b;
    logic flag_b_prev, ferr_b_prev;

    uart_rx #(.CLKS_PER_BIT(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_line (line_a),
        .flag      (flag_a),
        .data_byte (byte_a),
        .frame_err (ferr_a)
    );

    uart_rx #(.CLKS_PER_BIT(16)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_line (line_b),
        .flag      (flag_b),
        .data_byte (byte_b),
        .frame_err (ferr_b)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        flag_a_prev <= flag_a;
        ferr_a_prev <= ferr_a;
        flag_b_prev <= flag_b;
        ferr_b_prev <= ferr_b;
        if (flag_a) begin
            fa_hi <= fa_hi + 1;
            if (!flag_a_prev) begin
                fa_pulses    <= fa_pulses + 1;
                fa_prev_cyc  <= fa_last_cyc;
                fa_last_cyc  <= cyc;
                fa_prev_byte <= fa_last_byte;
                fa_last_byte <= byte_a;
            end
        end
        if (ferr_a) begin
            ea_hi <= ea_hi + 1;
            if (!ferr_a_prev) ea_pulses <= ea_pulses + 1;
        end
        if (flag_a && ferr_a) both_a <= both_a + 1;
        if (flag_b && !flag_b_prev) begin
            fb_pulses   <= fb_pulses + 1;
            fb_last_cyc <= cyc;
        end
        if (ferr_b && !ferr_b_prev) eb_pulses <= eb_pulses + 1;
        if (flag_b && ferr_b) both_b <= both_b + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) line_a = v;
        else            line_b = v;
    endtask

    // Must be entered on a falling edge; leaves the line at the stop value.
    task automatic send_frame(input int which, input logic [7:0] b, input logic stop_v,
                              input int cpb, output int t0);
        t0 = cyc;
        set_line(which, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(which, b[i]);
            repeat (cpb) @(negedge clk);
        end
        set_line(which, stop_v);
        repeat (cpb) @(negedge clk);
    endtask

    task automatic idle(input int n);
        line_a = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    int t0, p0, e0, h0;
    logic [7:0] v3c;

    initial begin
        cyc = 0; n_checks = 0; n_pass = 0;
        fa_hi = 0; fa_pulses = 0; fa_last_cyc = 0; fa_prev_cyc = 0;
        ea_hi = 0; ea_pulses = 0; both_a = 0;
        fa_last_byte = 8'h00; fa_prev_byte = 8'h00;
        flag_a_prev = 1'b0; ferr_a_prev = 1'b0;
        fb_pulses = 0; fb_last_cyc = 0; eb_pulses = 0; both_b = 0;
        flag_b_prev = 1'b0; ferr_b_prev = 1'b0;
        line_a = 1'b1; line_b = 1'b1;
        rst_n  = 1'b0;
        #3;
        check_eq("reset_flag", {31'd0, flag_a}, 32'd0);
        check_eq("reset_byte", {24'd0, byte_a}, 32'h00);
        check_eq("reset_ferr", {31'd0, ferr_a}, 32'd0);
        check_eq("reset_byte_b", {24'd0, byte_b}, 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // 1: good frame 0x5D
        send_frame(0, 8'h5D, 1'b1, 8, t0);
        idle(20);
        check_eq("good_pulses", fa_pulses, 32'd1);
        check_eq("good_width", fa_hi, 32'd1);
        check_eq("good_byte", {24'd0, byte_a}, 32'h5D);
        check_eq("good_latency", fa_last_cyc - t0, 32'd79);
        check_eq("good_no_ferr", ea_pulses, 32'd0);

        // 2: framing errors, the last one with the line held low for a long time
        do_reset();
        p0 = fa_pulses; e0 = ea_pulses; h0 = ea_hi;
        idle(8);
        for (int r = 0; r < 2; r++) begin
            send_frame(0, 8'h5D, 1'b0, 8, t0);
            idle(8);
        end
        send_frame(0, 8'h5D, 1'b0, 8, t0);
        repeat (100) @(negedge clk);
        idle(20);
        check_eq("ferr_pulses", ea_pulses - e0, 32'd3);
        check_eq("ferr_width", ea_hi - h0, 32'd3);
        check_eq("ferr_no_flag", fa_pulses - p0, 32'd0);
        check_eq("ferr_byte", {24'd0, byte_a}, 32'h00);

        // 3: start glitch, then a good 0xA5
        p0 = fa_pulses; e0 = ea_pulses;
        line_a = 1'b0;
        repeat (2) @(negedge clk);
        idle(100);
        check_eq("glitch_no_flag", fa_pulses - p0, 32'd0);
        check_eq("glitch_no_ferr", ea_pulses - e0, 32'd0);
        send_frame(0, 8'hA5, 1'b1, 8, t0);
        idle(20);
        check_eq("glitch_next_flag", fa_pulses - p0, 32'd1);
        check_eq("glitch_next_byte", {24'd0, byte_a}, 32'hA5);
        check_eq("glitch_next_latency", fa_last_cyc - t0, 32'd79);

        // 4: back-to-back 0x00 then 0xFF
        p0 = fa_pulses;
        send_frame(0, 8'h00, 1'b1, 8, t0);
        send_frame(0, 8'hFF, 1'b1, 8, t0);
        idle(20);
        check_eq("b2b_pulses", fa_pulses - p0, 32'd2);
        check_eq("b2b_first", {24'd0, fa_prev_byte}, 32'h00);
        check_eq("b2b_second", {24'd0, fa_last_byte}, 32'hFF);
        check_eq("b2b_spacing", fa_last_cyc - fa_prev_cyc, 32'd80);
        check_eq("b2b_byte", {24'd0, byte_a}, 32'hFF);

        // 5: reset during data bit 4 of a 0x3C frame, released during its stop bit
        p0 = fa_pulses;
        v3c = 8'h3C;
        line_a = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            line_a = v3c[i];
            repeat (8) @(negedge clk);
        end
        line_a = v3c[4];
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_byte", {24'd0, byte_a}, 32'h00);
        check_eq("midrst_flag", {31'd0, flag_a}, 32'd0);
        check_eq("midrst_ferr", {31'd0, ferr_a}, 32'd0);
        repeat (4) @(negedge clk);
        for (int i = 5; i < 8; i++) begin
            line_a = v3c[i];
            repeat (8) @(negedge clk);
        end
        line_a = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(100);
        check_eq("midrst_no_flag", fa_pulses - p0, 32'd0);
        send_frame(0, 8'h3C, 1'b1, 8, t0);
        idle(20);
        check_eq("midrst_next_flag", fa_pulses - p0, 32'd1);
        check_eq("midrst_next_byte", {24'd0, byte_a}, 32'h3C);

        // 6: 16 clocks per bit, frame 0x81
        send_frame(1, 8'h81, 1'b1, 16, t0);
        line_b = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("sweep_pulses", fb_pulses, 32'd1);
        check_eq("sweep_byte", {24'd0, byte_b}, 32'h81);
        check_eq("sweep_latency", fb_last_cyc - t0, 32'd155);
        check_eq("sweep_no_ferr", eb_pulses, 32'd0);

        check_eq("never_both_a", both_a, 32'd0);
        check_eq("never_both_b", both_b, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
